// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial source and its hold register.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_WIDTH_DEF = 8;

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry word buffer that lets the next word wait while the current one shifts.
module ser_hold_reg
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic [WIDTH-1:0] rd_data
);

  // Fill on write, drain on read; the two never coincide since writes need full=0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full    <= 1'b0;
      rd_data <= '0;
    end else if (wr_en) begin
      full    <= 1'b1;
      rd_data <= wr_data;
    end else if (rd_en) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial front end: words in over valid/ready, one registered bit per clk out.
module serial_bit_source
  import serial_pkg::*;
#(
  parameter int   WIDTH     = SER_WIDTH_DEF,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             x_out,
  output logic             x_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("serial_bit_source: WIDTH must be in 2..32");
  end

  function automatic logic out_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
  endfunction

  ser_state_t       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             at_last;
  logic             hold_wr;
  logic             hold_rd;
  logic             load_en;
  logic             adv_en;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] next_word;

  assign in_ready = reset_n & ~hold_full;
  assign busy     = (state == ST_SHIFT) | hold_full;

  // Decode accept and what the next edge does to the shifter.
  always_comb begin
    accept    = in_valid & in_ready;
    at_last   = (state == ST_SHIFT) && (bit_cnt == CNT_LAST);
    hold_wr   = accept && (state == ST_SHIFT) && !at_last;
    hold_rd   = at_last && hold_full;
    load_en   = ((state == ST_IDLE) && accept) || (at_last && (hold_full || accept));
    adv_en    = (state == ST_SHIFT) && !at_last;
    load_word = hold_full ? hold_data : in_data;
    next_word = shift_word(shift_reg);
  end

  ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (hold_wr),
    .wr_data (in_data),
    .rd_en   (hold_rd),
    .full    (hold_full),
    .rd_data (hold_data)
  );

  // Shifter FSM; outputs are computed one edge early so they leave from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      x_out     <= IDLE_BIT;
      x_valid   <= 1'b0;
      first_bit <= 1'b0;
      last_bit  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_SHIFT: begin
          if (load_en) begin
            state     <= ST_SHIFT;
            bit_cnt   <= '0;
            shift_reg <= load_word;
            x_out     <= out_bit(load_word);
            x_valid   <= 1'b1;
            first_bit <= 1'b1;
            last_bit  <= 1'b0;
          end else if (adv_en) begin
            bit_cnt   <= bit_cnt + CNT_W'(1);
            shift_reg <= next_word;
            x_out     <= out_bit(next_word);
            first_bit <= 1'b0;
            last_bit  <= (bit_cnt == CNT_PRE);
          end else begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            x_out     <= IDLE_BIT;
            x_valid   <= 1'b0;
            first_bit <= 1'b0;
            last_bit  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bit_cnt   <= '0;
          shift_reg <= '0;
          x_out     <= IDLE_BIT;
          x_valid   <= 1'b0;
          first_bit <= 1'b0;
          last_bit  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed self-checking bench for serial_bit_source (MSB-first and LSB-first instances).
module tb_serial_bit_source;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready, x_out, x_valid, first_bit, last_bit, busy;
  logic [7:0] in_data;
  logic       in_valid2, in_ready2, x_out2, x_valid2, first_bit2, last_bit2, busy2;
  logic [7:0] in_data2;
  logic [1:0] det_hist;
  logic       det;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .x_out(x_out), .x_valid(x_valid), .first_bit(first_bit),
    .last_bit(last_bit), .busy(busy)
  );

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .x_out(x_out2), .x_valid(x_valid2), .first_bit(first_bit2),
    .last_bit(last_bit2), .busy(busy2)
  );

  // Overlapping "101" detector fed by the serial stream; output is one cycle late.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      det_hist <= 2'b00;
      det      <= 1'b0;
    end else if (x_valid) begin
      det_hist <= {det_hist[0], x_out};
      det      <= (det_hist == 2'b10) && x_out;
    end else begin
      det_hist <= 2'b00;
      det      <= 1'b0;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_valid2 = 1'b0; in_data2 = 8'h00;
    @(negedge clk); @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (x_out !== 1'b0) begin n_fail++; $display("FAIL reset_x_out: got %b expected 0", x_out); end
    n_checks++; if ({x_valid, first_bit, last_bit, busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {x_valid, first_bit, last_bit, busy}); end
    reset_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] word;
    word = 8'hA5;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1; in_data = word;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (x_out !== word[8-i]) begin n_fail++; $display("FAIL single_x_out cycle %0d: got %b expected %b", i, x_out, word[8-i]); end
      n_checks++; if (x_valid !== 1'b1) begin n_fail++; $display("FAIL single_x_valid cycle %0d: got %b expected 1", i, x_valid); end
      n_checks++; if (first_bit !== (i == 1)) begin n_fail++; $display("FAIL single_first cycle %0d: got %b expected %b", i, first_bit, (i == 1)); end
      n_checks++; if (last_bit !== (i == 8)) begin n_fail++; $display("FAIL single_last cycle %0d: got %b expected %b", i, last_bit, (i == 8)); end
      @(negedge clk);
    end
    n_checks++; if ({x_out, x_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL single_idle: got %b expected 000", {x_out, x_valid, busy}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words [3];
    logic [23:0] stream;
    logic        exp_ready, exp_valid, exp_x;
    int          k;
    words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'hA5;
    stream = {8'hFF, 8'h00, 8'hA5};
    k = 0;
    for (int cyc = 0; cyc <= 25; cyc++) begin
      exp_ready = (cyc <= 1) || (cyc == 9) || (cyc >= 17);
      exp_valid = (cyc >= 1) && (cyc <= 24);
      if (exp_valid) exp_x = stream[24-cyc]; else exp_x = 1'b0;
      n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL b2b_ready cycle %0d: got %b expected %b", cyc, in_ready, exp_ready); end
      n_checks++; if (x_valid !== exp_valid) begin n_fail++; $display("FAIL b2b_x_valid cycle %0d: got %b expected %b", cyc, x_valid, exp_valid); end
      n_checks++; if (x_out !== exp_x) begin n_fail++; $display("FAIL b2b_x_out cycle %0d: got %b expected %b", cyc, x_out, exp_x); end
      if (cyc == 1 || cyc == 9 || cyc == 17) begin
        n_checks++; if (first_bit !== 1'b1) begin n_fail++; $display("FAIL b2b_first cycle %0d: got %b expected 1", cyc, first_bit); end
      end
      if (k < 3) begin in_valid = 1'b1; in_data = words[k]; end
      else begin in_valid = 1'b0; in_data = 8'h00; end
      if (in_valid && in_ready) k++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (k !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 3", k); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  words [3];
    logic [23:0] stream;
    logic        exp_x;
    int          k, acc3;
    words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'h5A;
    stream = {8'h3C, 8'hC3, 8'h5A};
    k = 0; acc3 = -1;
    for (int cyc = 0; cyc <= 25; cyc++) begin
      if (cyc >= 2 && cyc <= 9) begin
        n_checks++; if (in_ready !== (cyc == 9)) begin n_fail++; $display("FAIL bp_ready cycle %0d: got %b expected %b", cyc, in_ready, (cyc == 9)); end
      end
      if (cyc >= 9 && cyc <= 24) begin
        exp_x = stream[24-cyc];
        n_checks++; if (x_out !== exp_x) begin n_fail++; $display("FAIL bp_x_out cycle %0d: got %b expected %b", cyc, x_out, exp_x); end
      end
      if (k < 3) begin in_valid = 1'b1; in_data = words[k]; end
      else begin in_valid = 1'b0; in_data = 8'h00; end
      if (in_valid && in_ready) begin
        if (k == 2) acc3 = cyc;
        k++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++; if (acc3 !== 9) begin n_fail++; $display("FAIL bp_third_accept_cycle: got %0d expected 9", acc3); end
    n_checks++; if (x_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b expected 0", x_valid); end
  endtask

  task automatic test_reset_mid();
    int valid_seen;
    in_valid = 1'b1; in_data = 8'hA5;
    @(negedge clk);
    in_data = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk); @(negedge clk);
    n_checks++; if ({x_valid, busy, in_ready} !== 3'b110) begin n_fail++; $display("FAIL mid_pre_reset: got %b expected 110", {x_valid, busy, in_ready}); end
    reset_n = 1'b0;
    #1;
    n_checks++; if ({x_out, x_valid, first_bit, last_bit, busy, in_ready} !== 6'b000000) begin n_fail++; $display("FAIL mid_async_clear: got %b expected 000000", {x_out, x_valid, first_bit, last_bit, busy, in_ready}); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_checks++; if ({x_out, in_ready} !== 2'b01) begin n_fail++; $display("FAIL mid_release: got %b expected 01", {x_out, in_ready}); end
    valid_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (x_valid || busy) valid_seen++;
    end
    n_checks++; if (valid_seen !== 0) begin n_fail++; $display("FAIL mid_no_resume: got %0d active cycles expected 0", valid_seen); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_bits;
    exp_bits = 8'b0000_0001;
    n_checks++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL lsb_ready: got %b expected 1", in_ready2); end
    in_valid2 = 1'b1; in_data2 = 8'h01;
    @(negedge clk);
    in_valid2 = 1'b0; in_data2 = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (x_out2 !== exp_bits[i-1]) begin n_fail++; $display("FAIL lsb_x_out cycle %0d: got %b expected %b", i, x_out2, exp_bits[i-1]); end
      n_checks++; if ({x_valid2, first_bit2, last_bit2} !== {1'b1, (i == 1), (i == 8)}) begin n_fail++; $display("FAIL lsb_flags cycle %0d: got %b expected %b", i, {x_valid2, first_bit2, last_bit2}, {1'b1, (i == 1), (i == 8)}); end
      @(negedge clk);
    end
    n_checks++; if ({x_out2, x_valid2, busy2} !== 3'b000) begin n_fail++; $display("FAIL lsb_idle: got %b expected 000", {x_out2, x_valid2, busy2}); end
  endtask

  task automatic test_detector();
    logic exp_det;
    for (int cyc = 0; cyc <= 18; cyc++) begin
      exp_det = (cyc == 4) || (cyc == 6);
      n_checks++; if (det !== exp_det) begin n_fail++; $display("FAIL det_out cycle %0d: got %b expected %b", cyc, det, exp_det); end
      if (cyc == 0) begin in_valid = 1'b1; in_data = 8'b1010_1000; end
      else if (cyc == 1) begin in_valid = 1'b1; in_data = 8'h00; end
      else begin in_valid = 1'b0; in_data = 8'h00; end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_lsb_first();
    test_detector();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Parallel-to-serial front end for the bit-serial sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clk on x_out.
- x_out is registered and gap-free across back-to-back words; it drives a detector's x input directly.
- A one-entry holding register lets the next word be accepted while the current word shifts.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, value driven on x_out when no word is shifting.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WIDTH  word to serialize; sampled on the accept edge.
- x_out  out  1  serial bit stream to the detector; registered.
- x_valid  out  1  high while x_out carries a data bit; registered.
- first_bit  out  1  high during the first bit of each word; registered.
- last_bit  out  1  high during the last bit of each word; registered.
- busy  out  1  shifter active or hold register full.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, hold_full=0, bit_cnt=0, shift_reg=0.
  - x_out=IDLE_BIT; x_valid=0, first_bit=0, last_bit=0, busy=0.
  - in_ready=0 while reset_n is low.
- Reset mid-word: the word in flight and any held word are discarded. No partial completion.
- Handshake:
  - in_ready = !hold_full (combinational from registered state).
  - Accept occurs when in_valid && in_ready at a rising edge.
  - in_data must be stable only in the accept cycle.
- States:
  - IDLE: no word shifting.
  - SHIFT: bit_cnt counts 0..WIDTH-1, width clog2(WIDTH).
- IDLE + accept:
  - Load in_data into shift_reg; go to SHIFT with bit_cnt=0.
  - The first bit appears on x_out in the cycle after the accept edge (latency 1), with first_bit=1 and x_valid=1.
- SHIFT, bit_cnt < WIDTH-1:
  - Each edge advances one bit (shift toward the output end per MSB_FIRST) and increments bit_cnt.
  - An accept in this state writes the hold register and sets hold_full.
- SHIFT, bit_cnt == WIDTH-1 (last bit is on x_out, last_bit=1). On the next edge:
  - hold_full=1: load the hold word into shift_reg, clear hold_full, bit_cnt=0, stay in SHIFT. in_ready was 0 this cycle, so there is no simultaneous accept.
  - hold_full=0 and accept: load in_data directly into shift_reg, stay in SHIFT.
  - Neither case: go to IDLE; x_out=IDLE_BIT, x_valid=0.
- Result: with in_valid held high, the output is continuous with no idle bit between words.
- WIDTH=1 is illegal; WIDTH > 32 is illegal. Guard both with an elaboration-time check.
- x_out, x_valid, first_bit and last_bit come from flops; there are no combinational paths from inputs to these outputs.
- busy = (state==SHIFT) || hold_full.

Decomposition:
- Shared package serial_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Default width constant SER_WIDTH_DEF=8.
- One natural sub-module: ser_hold_reg. It is the one-entry WIDTH-bit holding register with a full flag, a write on accept-while-shifting, and a read on the last-bit edge.
- The shifter and counter stay in the top level.

Test Plan:
- Single word, MSB_FIRST=1, in_data=8'hA5 accepted at edge 0: x_out = 1,0,1,0,0,1,0,1 in cycles 1..8; first_bit high in cycle 1; last_bit high in cycle 8; x_out=0 and x_valid=0 from cycle 9.
- Back-to-back 8'hFF, 8'h00, 8'hA5 with in_valid held high: 24 contiguous valid bits, x_valid never drops. in_ready pattern: 1 at accept, 0 while hold is full, 1 again after each last-bit edge.
- Backpressure: hold a second word while the first shifts, then present a third. in_ready stays 0 until the edge after the first word's last bit; the third word is not accepted early.
- Reset mid-word: assert reset_n low during bit 4 of 8'hA5 with a word held. Outputs clear immediately (async); after release x_out=0 and in_ready=1; neither the remainder nor the held word is ever sent.
- MSB_FIRST=0, in_data=8'h01: x_out = 1,0,0,0,0,0,0,0.
- Chained with the 101 detector: words 8'b1010_1000, 8'h00 produce detector output high in the cycle after the 3rd bit and again after the 5th bit, and low otherwise.
